// File: rtl/instr_controller.sv
// Instruction register, decoder and Moore sequencer for the simple datapath.
// One micro-step per clock; w=1 means idle in WAIT and ready for s/load.
module instr_controller #(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WR_REG
  } state_t;

  typedef struct packed {
    logic       w;
    logic       illegal;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctl_t;

  state_t      state;
  state_t      nxt_state;
  logic [15:0] ir;
  logic [15:0] nxt_ir;
  ctl_t        ctl;

  // First micro-step after DECODE for a given instruction; WAIT means undecodable.
  function automatic state_t decode_target(input logic [15:0] i);
    case ({i[15:13], i[12:11]})
      5'b110_10: decode_target = S_WR_IMM;
      5'b110_00: decode_target = S_GET_B;
      5'b101_11: decode_target = S_GET_B;
      5'b101_00,
      5'b101_01,
      5'b101_10: decode_target = S_GET_A;
      default:   decode_target = S_WAIT;
    endcase
  endfunction

  function automatic state_t next_state(input state_t st, input logic [15:0] i,
                                        input logic start);
    case (st)
      S_WAIT:   next_state = start ? S_DECODE : S_WAIT;
      S_DECODE: next_state = decode_target(i);
      S_GET_A:  next_state = S_GET_B;
      S_GET_B:  next_state = S_ALU;
      S_ALU:    next_state = (i[15:11] == 5'b101_01) ? S_WAIT : S_WR_REG;
      default:  next_state = S_WAIT;
    endcase
  endfunction

  function automatic ctl_t ctl_for(input state_t st, input logic [15:0] i);
    logic mov_reg;
    logic is_cmp;
    mov_reg = (i[15:13] == 3'b110);
    is_cmp  = (i[15:11] == 5'b101_01);
    ctl_for = '0;
    case (st)
      S_WAIT:   ctl_for.w = 1'b1;
      S_DECODE: ctl_for.illegal = STRICT_DECODE && (decode_target(i) == S_WAIT);
      S_WR_IMM: begin
        ctl_for.write    = 1'b1;
        ctl_for.writenum = i[10:8];
        ctl_for.vsel     = 2'b10;
      end
      S_GET_A: begin
        ctl_for.readnum = i[10:8];
        ctl_for.loada   = 1'b1;
      end
      S_GET_B: begin
        ctl_for.readnum = i[2:0];
        ctl_for.loadb   = 1'b1;
      end
      S_ALU: begin
        ctl_for.shift = i[4:3];
        ctl_for.asel  = mov_reg;
        ctl_for.aluop = mov_reg ? 2'b00 : i[12:11];
        ctl_for.loads = is_cmp;
        ctl_for.loadc = !is_cmp;
      end
      S_WR_REG: begin
        ctl_for.write    = 1'b1;
        ctl_for.writenum = i[7:5];
      end
      default: ctl_for = '0;
    endcase
  endfunction

  // IR is only writable while idle; a simultaneous s executes the freshly loaded word.
  assign nxt_ir    = (state == S_WAIT && load) ? in : ir;
  assign nxt_state = next_state(state, nxt_ir, s);

  // NOTE: outputs are registered by decoding the *next* state and IR, so they
  // stay pure Moore functions of the current state without a combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
      ctl   <= ctl_for(S_WAIT, '0);
    end else begin
      state <= nxt_state;
      ir    <= nxt_ir;
      ctl   <= ctl_for(nxt_state, nxt_ir);
    end
  end

  assign w        = ctl.w;
  assign illegal  = ctl.illegal;
  assign readnum  = ctl.readnum;
  assign writenum = ctl.writenum;
  assign write    = ctl.write;
  assign vsel     = ctl.vsel;
  assign loada    = ctl.loada;
  assign loadb    = ctl.loadb;
  assign loadc    = ctl.loadc;
  assign loads    = ctl.loads;
  assign asel     = ctl.asel;
  assign bsel     = ctl.bsel;
  assign shift    = ctl.shift;
  assign ALUop    = ctl.aluop;
  assign sximm8   = {{8{ir[7]}}, ir[7:0]};

endmodule
